// File: rtl/carry_mask_collector_pkg.sv
// Shared definitions for the carry/borrow mask collector: element widths,
// collector FSM states and the add/sub polarity.
package carry_mask_collector_pkg;

  localparam int VLEN_DEF = 512;
  localparam int VLW_DEF  = 10;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  // Same polarity as the adder operand mux: 1 selects a+~b+1
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [3:0] elems_per_beat(input sew_e sew);
    return 4'(4'd8 >> sew);
  endfunction

endpackage

// File: rtl/carry_mask_collector_lane_extract.sv
// Picks the carry-out of each element's most significant byte slice from one
// adder beat and turns it into a carry (add) or borrow (sub) bit.
module carry_lane_extract
  import carry_mask_collector_pkg::*;
(
  input  logic [7:0] carry_out_i,
  input  sew_e       vsew,
  input  logic       add_sub,
  output logic [7:0] elem_bits,
  output logic [3:0] epb
);

  // Borrow is the inverted carry of a+~b+1; unused upper lanes read 0
  always_comb begin
    epb       = elems_per_beat(vsew);
    elem_bits = '0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < epb) begin
        elem_bits[j] = carry_out_i[3'(((j + 1) << vsew) - 1)] ^ (add_sub == OP_SUB);
      end
    end
  end

endmodule

// File: rtl/carry_mask_collector.sv
// Collects per-element carry/borrow bits from successive adder beats into a
// VLEN-bit mask and hands the finished mask downstream over valid/ready.
module carry_mask_collector
  import carry_mask_collector_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int VLW  = VLW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [VLW-1:0]  vl_i,
  input  logic [1:0]      vsew_i,
  input  logic            add_sub_i,
  input  logic            beat_valid_i,
  output logic            beat_ready_o,
  input  logic [7:0]      carry_out_i,
  output logic [VLEN-1:0] mask_o,
  output logic            mask_valid_o,
  input  logic            mask_ready_i,
  output logic            busy_o
);

  localparam int IW = $clog2(VLEN);

  state_e          state_q, state_d;
  logic [VLW-1:0]  ptr_q, vl_q, ptr_next, vl_clamped;
  sew_e            vsew_q;
  logic            add_sub_q;
  logic [7:0]      elem_bits;
  logic [3:0]      epb;
  logic            start_fire, beat_fire;
  logic [VLW:0]    ptr_sum, lane_idx;
  logic [VLEN-1:0] mask_d;

  carry_lane_extract u_extract (
    .carry_out_i (carry_out_i),
    .vsew        (vsew_q),
    .add_sub     (add_sub_q),
    .elem_bits   (elem_bits),
    .epb         (epb)
  );

  assign beat_ready_o = (state_q == ST_COLLECT);
  assign busy_o       = (state_q != ST_IDLE);
  assign start_fire   = (state_q == ST_IDLE) && start_i;
  assign beat_fire    = beat_ready_o && beat_valid_i;
  assign vl_clamped   = (vl_i > VLW'(VLEN)) ? VLW'(VLEN) : vl_i;
  assign ptr_sum      = {1'b0, ptr_q} + (VLW+1)'(epb);
  assign ptr_next     = ptr_sum[VLW] ? '1 : ptr_sum[VLW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = (vl_clamped == '0) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: if (beat_valid_i && (ptr_sum >= {1'b0, vl_q})) state_d = ST_DONE;
      ST_DONE:    if (mask_ready_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Lanes that land at or beyond vl are dropped so tail bits stay 0
  always_comb begin
    mask_d   = mask_o;
    lane_idx = '0;
    if (start_fire) begin
      mask_d = '0;
    end else if (beat_fire) begin
      for (int j = 0; j < 8; j++) begin
        lane_idx = {1'b0, ptr_q} + (VLW+1)'(j);
        if ((4'(j) < epb) && (lane_idx < {1'b0, vl_q})) begin
          mask_d[lane_idx[IW-1:0]] = elem_bits[j];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      vl_q         <= '0;
      vsew_q       <= SEW_8;
      add_sub_q    <= OP_ADD;
      mask_o       <= '0;
      mask_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_o       <= mask_d;
      mask_valid_o <= (state_d == ST_DONE);
      if (start_fire) begin
        vl_q      <= vl_clamped;
        vsew_q    <= sew_e'(vsew_i);
        add_sub_q <= add_sub_i;
        ptr_q     <= '0;
      end else if (beat_fire) begin
        ptr_q <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_carry_mask_collector.sv
// Scoreboard bench for carry_mask_collector: a driver pushes the mask a
// reference model predicts, and a monitor pops it when mask_valid_o appears.
module tb_carry_mask_collector;
  import carry_mask_collector_pkg::*;

  localparam int VLEN = 512;
  localparam int VLW  = 10;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [VLW-1:0]  vl_i = '0;
  logic [1:0]      vsew_i = '0;
  logic            add_sub_i = 1'b0;
  logic            beat_valid_i = 1'b0;
  logic            beat_ready_o;
  logic [7:0]      carry_out_i = '0;
  logic [VLEN-1:0] mask_o;
  logic            mask_valid_o;
  logic            mask_ready_i = 1'b0;
  logic            busy_o;

  int              checks = 0;
  int              errors = 0;
  logic [VLEN-1:0] exp_q[$];
  logic [7:0]      beat_data[512];
  bit              hold_ready = 1'b0;
  bit              seen = 1'b0;
  logic [VLEN-1:0] held;

  carry_mask_collector #(.VLEN(VLEN), .VLW(VLW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .vl_i         (vl_i),
    .vsew_i       (vsew_i),
    .add_sub_i    (add_sub_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .carry_out_i  (carry_out_i),
    .mask_o       (mask_o),
    .mask_valid_o (mask_valid_o),
    .mask_ready_i (mask_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream sink: random backpressure unless a test holds it off
  always @(negedge clk_i) begin
    if (hold_ready) mask_ready_i = 1'b0;
    else mask_ready_i = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk_i) begin
    if (!rst_i && mask_valid_o) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_mask actual=%0h required=none", mask_o);
          held = mask_o;
        end else begin
          held = exp_q.pop_front();
          checkOutput("mask", mask_o, held);
        end
      end else begin
        checkOutput("mask_stable", mask_o, held);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic waitIdle();
    int cnt = 0;
    while (busy_o && cnt < 400) begin
      @(negedge clk_i);
      cnt++;
    end
    checkOutput("idle_timeout", VLEN'(busy_o), '0);
  endtask

  // Reference: element e lives in beat e/epb; its carry comes from the top byte of its lane
  task automatic applyStimulus(input int vl_in, input int sew, input bit sub, input bit gaps, input bit poke_start);
    int vl_eff, epb, bpe, nbeats, cnt;
    logic [VLEN-1:0] exp;
    logic [7:0] byte_v;
    vl_eff = (vl_in > VLEN) ? VLEN : vl_in;
    epb    = 8 >> sew;
    bpe    = 8 / epb;
    nbeats = (vl_eff + epb - 1) / epb;
    exp    = '0;
    for (int e = 0; e < vl_eff; e++) begin
      byte_v = beat_data[e / epb];
      exp[e] = byte_v[((e % epb) + 1) * bpe - 1] ^ sub;
    end
    waitIdle();
    exp_q.push_back(exp);
    start_i   = 1'b1;
    vl_i      = VLW'(vl_in);
    vsew_i    = 2'(sew);
    add_sub_i = sub;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
      beat_valid_i = 1'b1;
      carry_out_i  = beat_data[b];
      if (poke_start && b == 0) begin
        start_i = 1'b1;
        vl_i    = '0;
      end
      cnt = 0;
      while (!beat_ready_o && cnt < 50) begin
        @(negedge clk_i);
        cnt++;
      end
      if (!beat_ready_o) begin
        checkOutput("beat_ready_timeout", '0, VLEN'(1));
        beat_valid_i = 1'b0;
        start_i      = 1'b0;
        return;
      end
      if (b == nbeats - 1) checkOutput("valid_early", VLEN'(mask_valid_o), '0);
      @(negedge clk_i);
      beat_valid_i = 1'b0;
      start_i      = 1'b0;
    end
    checkOutput("valid_latency", VLEN'(mask_valid_o), VLEN'(1));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rst_busy", VLEN'(busy_o), '0);
    checkOutput("rst_valid", VLEN'(mask_valid_o), '0);
    checkOutput("rst_ready", VLEN'(beat_ready_o), '0);
    checkOutput("rst_mask", mask_o, '0);

    beat_data[0] = 8'hA5;
    beat_data[1] = 8'h0F;
    applyStimulus(16, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("add_sew8", mask_o, VLEN'(16'h0FA5));

    beat_data[0] = 8'b1000_0000;
    applyStimulus(4, 1, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_sew16", mask_o, VLEN'(4'b0111));

    beat_data[0] = 8'h80;
    beat_data[1] = 8'h00;
    beat_data[2] = 8'h80;
    beat_data[3] = 8'h80;
    applyStimulus(3, 3, 1'b0, 1'b0, 1'b0);
    checkOutput("add_sew64", mask_o, VLEN'(3'b101));
    beat_valid_i = 1'b1;
    carry_out_i  = 8'h80;
    checkOutput("extra_beat_ready", VLEN'(beat_ready_o), '0);
    @(negedge clk_i);
    beat_valid_i = 1'b0;

    beat_data[0] = 8'hFF;
    applyStimulus(5, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("partial_beat", mask_o, VLEN'(5'h1F));

    applyStimulus(0, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("vl_zero", mask_o, '0);

    beat_data[0] = 8'h3C;
    beat_data[1] = 8'hC3;
    applyStimulus(12, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("start_in_collect", mask_o, VLEN'(12'h33C));

    waitIdle();
    hold_ready   = 1'b1;
    mask_ready_i = 1'b0;
    beat_data[0] = 8'h96;
    applyStimulus(8, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_valid", VLEN'(mask_valid_o), VLEN'(1));
      checkOutput("hold_mask", mask_o, VLEN'(8'h69));
      @(negedge clk_i);
    end
    hold_ready = 1'b0;

    waitIdle();
    start_i   = 1'b1;
    vl_i      = VLW'(16);
    vsew_i    = 2'b00;
    add_sub_i = 1'b0;
    @(negedge clk_i);
    start_i      = 1'b0;
    beat_valid_i = 1'b1;
    carry_out_i  = 8'hFF;
    @(negedge clk_i);
    beat_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("abort_busy", VLEN'(busy_o), '0);
    checkOutput("abort_mask", mask_o, '0);
    checkOutput("abort_valid", VLEN'(mask_valid_o), '0);
    checkOutput("abort_ready", VLEN'(beat_ready_o), '0);
    beat_data[0] = 8'h5A;
    beat_data[1] = 8'hF0;
    applyStimulus(16, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_abort", mask_o, VLEN'(16'hF05A));

    for (int t = 0; t < 25; t++) begin
      int r, vl;
      r = $urandom_range(0, 9);
      if (r == 0) vl = 0;
      else if (r == 1) vl = $urandom_range(500, 1023);
      else vl = $urandom_range(1, 40);
      for (int k = 0; k < 512; k++) beat_data[k] = 8'($urandom);
      applyStimulus(vl, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    waitIdle();
    repeat (2) @(negedge clk_i);
    checkOutput("queue_empty", VLEN'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
